pc_unit: RTL

Parametrised fetch-stage program counter with stall hold, execute-stage redirect, and an integrated direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It replaces the plain PC register at the head of the pipelined core. Each cycle it presents the current fetch PC plus a taken/target prediction to IF. It computes the next PC from that prediction unless the PC is held or redirected.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_unit_if.sv | 25 ++
 rtl/btb_dm.sv | 58 +++++
 rtl/pc_unit.sv | 44 ++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared BTB entry type, counter encodings and saturating counter update.
package pc_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // tag is stored at full width; only the bits above the index are ever non-zero
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side control inputs, EX training port and prediction outputs of pc_unit.
interface pc_unit_if #(parameter int XLEN = 32);

    logic            Stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [XLEN-1:0] PC;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output Stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
        input  PC, pred_taken, pred_target
    );

    modport slave (
        input  Stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
        output PC, pred_taken, pred_target
    );

endinterface

// File: rtl/btb_dm.sv
// btb_dm: direct-mapped branch target buffer, combinational lookup and edge-triggered training.
module btb_dm #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_taken_i
);
    import pc_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int EW    = pc_pkg::XLEN;

    btb_entry_t       entries_q [ENTRIES];
    btb_entry_t       rd_e, wr_e, wr_d;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             rd_hit, wr_hit, wr_en;

    function automatic logic [EW-1:0] tag_of(input logic [XLEN-1:0] pc);
        return EW'(pc >> (IDX_W + 2));
    endfunction

    always_comb begin
        rd_idx   = lookup_pc_i[IDX_W+1:2];
        rd_e     = entries_q[rd_idx];
        rd_hit   = rd_e.valid && (rd_e.tag == tag_of(lookup_pc_i));
        taken_o  = rd_hit && rd_e.ctr[1];
        target_o = rd_e.target[XLEN-1:0];
    end

    // a miss only writes when taken, so the miss path always allocates a weakly-taken entry
    always_comb begin
        wr_idx      = upd_pc_i[IDX_W+1:2];
        wr_e        = entries_q[wr_idx];
        wr_hit      = wr_e.valid && (wr_e.tag == tag_of(upd_pc_i));
        wr_en       = upd_valid_i && (wr_hit || upd_taken_i);
        wr_d.valid  = 1'b1;
        wr_d.tag    = tag_of(upd_pc_i);
        wr_d.target = upd_taken_i ? EW'(upd_target_i) : wr_e.target;
        wr_d.ctr    = wr_hit ? ctr_update(wr_e.ctr, upd_taken_i) : CTR_WT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
        end else if (wr_en) begin
            entries_q[wr_idx] <= wr_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with redirect/stall priority and BTB-driven next-PC prediction.
module pc_unit #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    import pc_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, seq_pc, btb_target, pred_pc;
    logic            btb_taken;

    btb_dm #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc_i  (pc_q),
        .taken_o      (btb_taken),
        .target_o     (btb_target),
        .upd_valid_i  (bus.upd_valid),
        .upd_pc_i     (bus.upd_pc),
        .upd_target_i (bus.upd_target),
        .upd_taken_i  (bus.upd_taken)
    );

    // redirect beats stall so a mispredict is never lost while the hazard unit holds fetch
    always_comb begin
        seq_pc  = pc_q + XLEN'(4);
        pred_pc = btb_taken ? btb_target : seq_pc;
        pc_d    = bus.redirect_valid ? bus.redirect_pc : bus.Stall ? pc_q : pred_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign bus.PC          = pc_q;
    assign bus.pred_taken  = btb_taken;
    assign bus.pred_target = pred_pc;

endmodule
